instruction_fetch_loader: RTL and testbench



---
 rtl/instruction_fetch_loader_if.sv | 28 ++
 rtl/instruction_fetch_loader.sv | 103 ++++++++++
 tb/tb_instruction_fetch_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_loader_if.sv
// Loader and core-fetch signal bundle for instruction_fetch_loader.
// The slave side is the fetch loader; the master side drives the loader and the core requests.
interface instruction_fetch_loader_if #(
    parameter int unsigned AW = 8
) ();
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          reload;
    logic [15:0]   count;
    logic          read_i;
    logic [31:0]   I;
    logic          cpu_start;
    logic [AW:0]   words_loaded;
    logic          full;
    logic          halted;

    modport master (
        output load_valid, load_data, load_last, reload, count, read_i,
        input  load_ready, I, cpu_start, words_loaded, full, halted
    );

    modport slave (
        input  load_valid, load_data, load_last, reload, count, read_i,
        output load_ready, I, cpu_start, words_loaded, full, halted
    );
endinterface

// File: rtl/instruction_fetch_loader.sv
// Instruction store for the core: boots via a valid/ready loader port, holds the core in
// reset until a program is loaded, then serves fetches with one cycle of latency.
module instruction_fetch_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter logic [31:0] HALT_WORD = 32'h12000000
) (
    input logic                         clk1,
    input logic                         start,
    instruction_fetch_loader_if.slave   bus
);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e         state_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    words_q;
    logic [31:0]    instr_q;
    logic           cpu_start_q;
    logic           load_ready_q;
    logic           full_q;
    logic           halted_q;
    logic [31:0]    mem_q [DEPTH];

    logic           xfer;
    logic           at_end;
    logic [15:0]    words_ext;
    logic [31:0]    fetch_word;

    always_comb begin
        xfer       = (state_q == StLoad) && load_ready_q && bus.load_valid;
        at_end     = (wr_ptr_q == AW'(DEPTH - 1));
        words_ext  = 16'(words_q);
        // Full 16-bit compare so counts above DEPTH-1 never alias into the store.
        fetch_word = (bus.count < words_ext) ? mem_q[bus.count[AW-1:0]] : HALT_WORD;
    end

    always_ff @(posedge clk1) begin
        if (!start && xfer) begin
            mem_q[wr_ptr_q] <= bus.load_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (start) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            words_q      <= '0;
            instr_q      <= '0;
            cpu_start_q  <= 1'b1;
            load_ready_q <= 1'b0;
            full_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    cpu_start_q  <= 1'b1;
                    load_ready_q <= 1'b1;
                    if (xfer) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        words_q  <= words_q + (AW + 1)'(1);
                        // Filling the last slot without load_last ends the load as well.
                        if (bus.load_last || at_end) begin
                            state_q      <= StRun;
                            load_ready_q <= 1'b0;
                            full_q       <= !bus.load_last;
                        end
                    end
                end
                StRun: begin
                    if (bus.reload) begin
                        state_q      <= StLoad;
                        cpu_start_q  <= 1'b1;
                        load_ready_q <= 1'b1;
                        wr_ptr_q     <= '0;
                        words_q      <= '0;
                        full_q       <= 1'b0;
                        halted_q     <= 1'b0;
                        instr_q      <= '0;
                    end else begin
                        cpu_start_q  <= 1'b0;
                        load_ready_q <= 1'b0;
                        if (bus.read_i) begin
                            instr_q <= fetch_word;
                            if (fetch_word == HALT_WORD) begin
                                halted_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.load_ready   = load_ready_q;
    assign bus.I            = instr_q;
    assign bus.cpu_start    = cpu_start_q;
    assign bus.words_loaded = words_q;
    assign bus.full         = full_q;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_instruction_fetch_loader.sv
// Randomized bench for instruction_fetch_loader against a word-array program model.
module tb_instruction_fetch_loader;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam logic [31:0] HALT  = 32'h12000000;

    logic clk1 = 1'b0;
    logic start;
    always #5 clk1 = ~clk1;

    instruction_fetch_loader_if #(.AW(AW)) bus ();

    instruction_fetch_loader #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .HALT_WORD (HALT)
    ) dut (
        .clk1  (clk1),
        .start (start),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] model_mem [DEPTH];
    int          model_words;
    logic [31:0] model_i;
    bit          model_halted;
    bit          model_full;
    logic [31:0] prog [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic model_clear();
        model_words  = 0;
        model_i      = '0;
        model_halted = 1'b0;
        model_full   = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".I"}, bus.I, model_i);
        check_eq({tag, ".words"}, 32'(bus.words_loaded), 32'(model_words));
        check_eq({tag, ".full"}, 32'(bus.full), 32'(model_full));
        check_eq({tag, ".halted"}, 32'(bus.halted), 32'(model_halted));
    endtask

    task automatic do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
        check_status("reset");
        check_eq("reset.cpu_start", 32'(bus.cpu_start), 32'd1);
        check_eq("reset.ready", 32'(bus.load_ready), 32'd0);
        step();
        check_eq("post_reset.ready", 32'(bus.load_ready), 32'd1);
    endtask

    // gap_mode: 0 back-to-back, 1 random idles, 2 valid toggling 1/0.
    task automatic send_words(input int gap_mode, input bit nolast);
        int idle;
        int t;
        for (int i = 0; i < prog.size(); i++) begin
            idle = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2 && i > 0) ? 1 : 0);
            repeat (idle) begin
                bus.load_valid = 1'b0;
                step();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_last  = !nolast && (i == prog.size() - 1);
            t = 0;
            while (!bus.load_ready && t < 20) begin
                step();
                t++;
            end
            check_eq("load.ready", 32'(bus.load_ready), 32'd1);
            step();
            model_mem[model_words] = prog[i];
            model_words++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic load_program(input int gap_mode, input bit nolast);
        send_words(gap_mode, nolast);
        model_full = nolast && (prog.size() == DEPTH);
        check_eq("load_end.ready", 32'(bus.load_ready), 32'd0);
        check_eq("load_end.cpu_start", 32'(bus.cpu_start), 32'd1);
        check_status("load_end");
        step();
        check_eq("run.cpu_start", 32'(bus.cpu_start), 32'd0);
    endtask

    task automatic fetch(input logic [15:0] c);
        logic [31:0] exp;
        bus.count  = c;
        bus.read_i = 1'b1;
        step();
        bus.read_i = 1'b0;
        exp = (int'(c) < model_words) ? model_mem[int'(c)] : HALT;
        if (exp == HALT) model_halted = 1'b1;
        model_i = exp;
        check_eq("fetch.I", bus.I, exp);
        check_eq("fetch.halted", 32'(bus.halted), 32'(model_halted));
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            bus.count = 16'($urandom);
            step();
            check_eq("hold.I", bus.I, model_i);
        end
    endtask

    task automatic reload_run(input bit with_read);
        bus.reload = 1'b1;
        bus.read_i = with_read;
        bus.count  = 16'd0;
        step();
        bus.reload = 1'b0;
        bus.read_i = 1'b0;
        model_clear();
        check_status("reload");
        check_eq("reload.cpu_start", 32'(bus.cpu_start), 32'd1);
        check_eq("reload.ready", 32'(bus.load_ready), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        start          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.reload     = 1'b0;
        bus.count      = '0;
        bus.read_i     = 1'b0;
        model_clear();
        #1;
        do_reset();

        prog = '{32'h02080000, 32'h04110000, HALT};
        load_program(0, 1'b0);
        fetch(16'd1);
        hold(5);
        fetch(16'd2);
        fetch(16'h0100);

        reload_run(1'b1);
        // Reload, fetches and words without valid are ignored while loading.
        bus.reload = 1'b1;
        bus.read_i = 1'b1;
        step();
        bus.reload = 1'b0;
        bus.read_i = 1'b0;
        check_status("load_ignore");
        check_eq("load_ignore.ready", 32'(bus.load_ready), 32'd1);
        check_eq("load_ignore.cpu_start", 32'(bus.cpu_start), 32'd1);
        prog = '{32'($urandom)};
        load_program(1, 1'b0);
        fetch(16'd0);
        fetch(16'd1);

        reload_run(1'b0);
        prog = {};
        for (int i = 0; i < DEPTH; i++) prog.push_back(32'($urandom));
        load_program(2, 1'b1);
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 32'hDEADBEEF;
        repeat (3) step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check_status("extra_valid");
        check_eq("extra_valid.ready", 32'(bus.load_ready), 32'd0);
        fetch(16'd0);
        fetch(16'd255);
        fetch(16'd128);
        fetch(16'd256);

        reload_run(1'b1);
        prog = '{32'($urandom), 32'($urandom)};
        send_words(0, 1'b1);
        check_eq("partial.words", 32'(bus.words_loaded), 32'd2);
        do_reset();
        prog = '{32'hABCD0001};
        load_program(0, 1'b0);
        fetch(16'd1);
        fetch(16'd0);

        for (int it = 0; it < 6; it++) begin
            reload_run(it[0]);
            n = int'($urandom_range(1, 24));
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back(32'($urandom));
            load_program(1, 1'b0);
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 3) == 0) fetch(16'($urandom));
                else fetch(16'($urandom_range(0, n + 2)));
                if ($urandom_range(0, 4) == 0) hold(2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
